uart_program_loader: RTL and testbench

Programmer-side consumer of the UART receiver's byte stream inside soc_top. Active while the programmer enable is high. Packs incoming bytes little-endian into 32-bit words and writes them sequentially into instruction memory through a valid/ready write port. Ends the session on an idle timeout or when memory is full, then reports done and the word count.

---
 rtl/loader_pkg.sv | 15 +
 rtl/loader_word_packer.sv | 62 ++++++
 rtl/uart_program_loader.sv | 146 ++++++++++++++
 tb/tb_uart_program_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the UART program loader: FSM states and the byte-lane index.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t LAST_BYTE = 2'd3;

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte packer with strobes and a one-byte skid for bytes
// that arrive while the previous word is still waiting for its grant.
module loader_word_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        collect_i,
    input  logic        hold_i,
    input  logic        commit_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output byte_idx_t   idx_o,
    output logic        store_o,
    output logic        word_full_o,
    output logic        drop_o,
    output logic        skid_valid_o
);

    logic       skid_valid;
    logic [7:0] skid_data;
    logic [7:0] store_byte;

    // A buffered byte is older than the live one, so it is packed first.
    assign store_o      = collect_i && (skid_valid || rx_valid_i);
    assign store_byte   = skid_valid ? skid_data : rx_data_i;
    assign word_full_o  = store_o && (idx_o == LAST_BYTE);
    assign drop_o       = hold_i && skid_valid && rx_valid_i;
    assign skid_valid_o = skid_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wdata_o    <= '0;
            wstrb_o    <= '0;
            idx_o      <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            if (commit_i) begin
                wdata_o <= '0;
                wstrb_o <= '0;
                idx_o   <= '0;
            end else if (store_o) begin
                wdata_o[8*idx_o +: 8] <= store_byte;
                wstrb_o[idx_o]        <= 1'b1;
                idx_o                 <= idx_o + 2'd1;
            end

            if (hold_i && rx_valid_i && !skid_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= rx_data_i;
            end else if (collect_i && skid_valid) begin
                skid_valid <= rx_valid_i;
                if (rx_valid_i) skid_data <= rx_data_i;
            end
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Streams UART bytes into instruction memory as 32-bit words.
// Define UART_PROGRAM_LOADER_CHECKSUM_EN to add a running checksum_o output.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int              MAX_WORDS    = 1024,
    parameter int              IDLE_TIMEOUT = 50_000
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             enable_i,
    input  logic                             rx_valid_i,
    input  logic [7:0]                       rx_data_i,
    output logic                             mem_req_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    output logic [31:0]                      mem_wdata_o,
    output logic [3:0]                       mem_wstrb_o,
    input  logic                             mem_gnt_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             overrun_o,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_count_o
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                      checksum_o
`endif
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     word_count, count_inc;
    logic [TW-1:0]     tmo_cnt;
    logic              timed_out, overrun;
    logic              store, word_full, drop, skid_valid;
    byte_idx_t         idx;
    logic              start, grant, mem_full, tmo_fire;

    assign start     = (state == IDLE) && enable_i;
    assign grant     = (state == WRITE) && mem_gnt_i;
    assign count_inc = word_count + CW'(1);
    assign mem_full  = (count_inc == CW'(MAX_WORDS));
    // A byte in the firing cycle wins: store suppresses the timeout.
    assign tmo_fire  = (state == COLLECT) && !store &&
                       (tmo_cnt == TW'(IDLE_TIMEOUT - 1));

    loader_word_packer u_packer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (state == IDLE),
        .collect_i   (state == COLLECT),
        .hold_i      (state == WRITE),
        .commit_i    (grant),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .wdata_o     (mem_wdata_o),
        .wstrb_o     (mem_wstrb_o),
        .idx_o       (idx),
        .store_o     (store),
        .word_full_o (word_full),
        .drop_o      (drop),
        .skid_valid_o(skid_valid)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (enable_i) state_n = COLLECT;
            end
            COLLECT: begin
                if (!enable_i)     state_n = IDLE;
                else if (word_full) state_n = WRITE;
                else if (tmo_fire)  state_n = (idx != '0) ? WRITE : DONE;
            end
            WRITE: begin
                if (grant && enable_i)
                    state_n = (timed_out || mem_full) ? DONE : COLLECT;
                else if (!enable_i)
                    state_n = IDLE;
            end
            DONE: begin
                if (!enable_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            addr       <= '0;
            word_count <= '0;
            tmo_cnt    <= '0;
            timed_out  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                addr       <= BASE_ADDR;
                word_count <= '0;
                tmo_cnt    <= '0;
                timed_out  <= 1'b0;
                overrun    <= 1'b0;
            end
            if (state == COLLECT) begin
                tmo_cnt <= store ? '0 : tmo_cnt + TW'(1);
                if (tmo_fire) timed_out <= 1'b1;
            end
            if (grant) begin
                word_count <= (word_count == CW'(MAX_WORDS)) ? word_count
                                                              : count_inc;
                addr       <= addr + ADDR_W'(4);
                tmo_cnt    <= '0;
            end
            // Anything still arriving once memory is full has nowhere to go.
            if (drop ||
                ((state == DONE) && rx_valid_i && (word_count == CW'(MAX_WORDS))) ||
                (grant && mem_full && (skid_valid || rx_valid_i)))
                overrun <= 1'b1;
        end
    end

`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;

    always_ff @(posedge clk_i) begin
        if (reset_i || start) checksum <= '0;
        else if (grant)       checksum <= checksum + mem_wdata_o;
    end

    assign checksum_o = checksum;
`endif

    assign mem_req_o    = (state == WRITE);
    assign mem_addr_o   = addr;
    assign busy_o       = (state == COLLECT) || (state == WRITE);
    assign done_o       = (state == DONE);
    assign overrun_o    = overrun;
    assign word_count_o = word_count;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: two instances, the second with a
// two-word memory to reach the memory-full path.
module tb_uart_program_loader;

    localparam logic [31:0] BASE_A = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_a = 1'b0;
    logic        enable_b = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        gnt = 1'b1;

    logic        req_a, busy_a, done_a, ovr_a;
    logic [31:0] addr_a, wdata_a;
    logic [3:0]  wstrb_a;
    logic [3:0]  wc_a;
    logic        req_b, busy_b, done_b, ovr_b;
    logic [31:0] addr_b, wdata_b;
    logic [3:0]  wstrb_b;
    logic [1:0]  wc_b;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] cks_a, cks_b;
`endif

    logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
    logic [3:0]  qa_strb[$], qb_strb[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_program_loader #(
        .ADDR_W(32), .BASE_ADDR(BASE_A), .MAX_WORDS(8), .IDLE_TIMEOUT(6)
    ) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable_a),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .mem_req_o(req_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a),
        .mem_wstrb_o(wstrb_a), .mem_gnt_i(gnt),
        .busy_o(busy_a), .done_o(done_a), .overrun_o(ovr_a),
        .word_count_o(wc_a)
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
        , .checksum_o(cks_a)
`endif
    );

    uart_program_loader #(
        .ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(2), .IDLE_TIMEOUT(6)
    ) dut_small (
        .clk_i(clk), .reset_i(reset), .enable_i(enable_b),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .mem_req_o(req_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b),
        .mem_wstrb_o(wstrb_b), .mem_gnt_i(gnt),
        .busy_o(busy_b), .done_o(done_b), .overrun_o(ovr_b),
        .word_count_o(wc_b)
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
        , .checksum_o(cks_b)
`endif
    );

    always @(posedge clk) begin
        if (!reset && req_a && gnt) begin
            qa_addr.push_back(addr_a);
            qa_data.push_back(wdata_a);
            qa_strb.push_back(wstrb_a);
        end
        if (!reset && req_b && gnt) begin
            qb_addr.push_back(addr_b);
            qb_data.push_back(wdata_b);
            qb_strb.push_back(wstrb_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_g(input logic [7:0] b);
        send(b);
        step();
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_a), 32'h1);
    endtask

    task automatic clear_logs();
        qa_addr.delete(); qa_data.delete(); qa_strb.delete();
        qb_addr.delete(); qb_data.delete(); qb_strb.delete();
    endtask

    initial begin
        idle(2);
        chk("rst_req", 32'(req_a), 32'h0);
        chk("rst_addr", addr_a, 32'h0);
        chk("rst_wdata", wdata_a, 32'h0);
        chk("rst_flags", {28'h0, wstrb_a}, 32'h0);
        chk("rst_state", {28'h0, busy_a, done_a, ovr_a, 1'b0}, 32'h0);
        chk("rst_count", 32'(wc_a), 32'h0);
        reset = 1'b0;

        // Eight back-to-back bytes, grant always high.
        enable_a = 1'b1;
        step();
        chk("t1_busy", 32'(busy_a), 32'h1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        wait_done_a("t1_done");
        chk("t1_nwr", 32'(qa_addr.size()), 32'd2);
        chk("t1_d0", qa_data[0], 32'h04030201);
        chk("t1_a0", qa_addr[0], BASE_A);
        chk("t1_s0", 32'(qa_strb[0]), 32'hF);
        chk("t1_d1", qa_data[1], 32'h08070605);
        chk("t1_a1", qa_addr[1], BASE_A + 32'd4);
        chk("t1_s1", 32'(qa_strb[1]), 32'hF);
        chk("t1_cnt", 32'(wc_a), 32'd2);
        chk("t1_ovr", 32'(ovr_a), 32'h0);
        chk("t1_busy_done", 32'(busy_a), 32'h0);
        enable_a = 1'b0;
        step();
        chk("t1_done_clr", 32'(done_a), 32'h0);
        chk("t1_cnt_kept", 32'(wc_a), 32'd2);

        // Six spaced bytes then silence: partial second word.
        clear_logs();
        enable_a = 1'b1;
        step();
        chk("t2_cnt_clr", 32'(wc_a), 32'd0);
        send_g(8'hAA); send_g(8'hBB); send_g(8'hCC);
        send_g(8'hDD); send_g(8'hEE); send_g(8'hFF);
        idle(4);
        chk("t2_no_req_early", 32'(req_a), 32'h0);
        step();
        chk("t2_req", 32'(req_a), 32'h1);
        chk("t2_pdata", wdata_a, 32'h0000FFEE);
        chk("t2_pstrb", 32'(wstrb_a), 32'h3);
        chk("t2_paddr", addr_a, BASE_A + 32'd4);
        step();
        chk("t2_done", 32'(done_a), 32'h1);
        chk("t2_nwr", 32'(qa_addr.size()), 32'd2);
        chk("t2_d0", qa_data[0], 32'hDDCCBBAA);
        chk("t2_d1", qa_data[1], 32'h0000FFEE);
        chk("t2_s1", 32'(qa_strb[1]), 32'h3);
        chk("t2_cnt", 32'(wc_a), 32'd2);
        enable_a = 1'b0;
        step();

        // Grant withheld: stable request, skid keeps one byte, next drops.
        clear_logs();
        gnt = 1'b0;
        enable_a = 1'b1;
        step();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("t3_req", 32'(req_a), 32'h1);
        send(8'h55);
        for (int i = 0; i < 8; i++) begin
            chk("t3_hold_req", 32'(req_a), 32'h1);
            chk("t3_hold_data", wdata_a, 32'h44332211);
            chk("t3_hold_addr", addr_a, BASE_A);
            chk("t3_hold_strb", 32'(wstrb_a), 32'hF);
            step();
        end
        chk("t3_no_ovr", 32'(ovr_a), 32'h0);
        send(8'h66);
        chk("t3_ovr", 32'(ovr_a), 32'h1);
        chk("t3_still_data", wdata_a, 32'h44332211);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        send(8'h77); send(8'h88); send(8'h99);
        step();
        chk("t3_req2", 32'(req_a), 32'h1);
        chk("t3_data2", wdata_a, 32'h99887755);
        chk("t3_addr2", addr_a, BASE_A + 32'd4);
        gnt = 1'b1;
        step();
        chk("t3_nwr", 32'(qa_addr.size()), 32'd2);
        chk("t3_d0", qa_data[0], 32'h44332211);
        chk("t3_ovr_sticky", 32'(ovr_a), 32'h1);
        enable_a = 1'b0;
        step();
        chk("t3_abort_busy", 32'(busy_a), 32'h0);

        // Abort mid-word, then restart from the base address.
        clear_logs();
        enable_a = 1'b1;
        step();
        chk("t5_ovr_clr", 32'(ovr_a), 32'h0);
        for (int i = 1; i <= 7; i++) send(8'(i));
        enable_a = 1'b0;
        step();
        chk("t5_busy", 32'(busy_a), 32'h0);
        chk("t5_done", 32'(done_a), 32'h0);
        chk("t5_req", 32'(req_a), 32'h0);
        idle(3);
        chk("t5_nwr", 32'(qa_addr.size()), 32'd1);
        chk("t5_cnt", 32'(wc_a), 32'd1);
        clear_logs();
        enable_a = 1'b1;
        step();
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        step();
        chk("t5_re_nwr", 32'(qa_addr.size()), 32'd1);
        chk("t5_re_addr", qa_addr[0], BASE_A);
        chk("t5_re_data", qa_data[0], 32'hC4C3C2C1);
        enable_a = 1'b0;
        step();

        // Reset while a write is pending.
        clear_logs();
        gnt = 1'b0;
        enable_a = 1'b1;
        step();
        send(8'h5A); send(8'h5B); send(8'h5C); send(8'h5D);
        chk("t6_req", 32'(req_a), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_req_rst", 32'(req_a), 32'h0);
        chk("t6_addr_rst", addr_a, 32'h0);
        chk("t6_wdata_rst", wdata_a, 32'h0);
        chk("t6_flags_rst", {24'h0, wstrb_a, busy_a, done_a, ovr_a, 1'b0}, 32'h0);
        chk("t6_cnt_rst", 32'(wc_a), 32'h0);
        chk("t6_nwr", 32'(qa_addr.size()), 32'd0);
        enable_a = 1'b0;
        gnt = 1'b1;
        step();

`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
        enable_a = 1'b1;
        step();
        send_g(8'hFF); send_g(8'hFF); send_g(8'hFF); send_g(8'hFF);
        send_g(8'h02); send_g(8'h00); send_g(8'h00); send_g(8'h00);
        wait_done_a("cks_done");
        chk("cks_value", cks_a, 32'h00000001);
        enable_a = 1'b0;
        step();
`endif

        // Two-word memory: twelve bytes fill it and the rest overrun.
        clear_logs();
        enable_b = 1'b1;
        step();
        for (int i = 1; i <= 12; i++) send_g(8'(i));
        chk("t4_nwr", 32'(qb_addr.size()), 32'd2);
        chk("t4_d0", qb_data[0], 32'h04030201);
        chk("t4_a1", qb_addr[1], 32'h4);
        chk("t4_d1", qb_data[1], 32'h08070605);
        chk("t4_s1", 32'(qb_strb[1]), 32'hF);
        chk("t4_done", 32'(done_b), 32'h1);
        chk("t4_busy", 32'(busy_b), 32'h0);
        chk("t4_ovr", 32'(ovr_b), 32'h1);
        chk("t4_cnt", 32'(wc_b), 32'd2);
        chk("t4_a_quiet", 32'(qa_addr.size()), 32'd0);
        enable_b = 1'b0;
        step();
        chk("t4_done_clr", 32'(done_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
